// File: rtl/kendall_pkg.sv
// Shared definitions for the Kendall-tau streaming block: FSM states,
// point/pair counts, coordinate width and the fixed pair evaluation order.
// Optional tie flag output is controlled by KENDALL_TIE_FLAG_EN.
package kendall_pkg;

  localparam int NUM_PTS   = 4;
  localparam int NUM_PAIRS = 6;
  localparam int COORD_W   = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pair k compares point PAIR_I[k] against point PAIR_J[k].
  localparam logic [1:0] PAIR_I [NUM_PAIRS] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
  localparam logic [1:0] PAIR_J [NUM_PAIRS] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd3};

  // Kendall numerator 2*conc - 6 as a 4-bit two's-complement value.
  function automatic logic [3:0] tau_of(input logic [2:0] conc);
    return {conc, 1'b0} - 4'd6;
  endfunction

endpackage

// File: rtl/kendall_pair_cmp.sv
// Purpose: classify one point pair as concordant and/or tied.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module kendall_pair_cmp
  import kendall_pkg::*;
(
  input  logic [COORD_W-1:0] xi,
  input  logic [COORD_W-1:0] yi,
  input  logic [COORD_W-1:0] xj,
  input  logic [COORD_W-1:0] yj,
  output logic               conc,
  output logic               tie
);

  // Unsigned strict less-than on both axes; ties fall on the "not less" side.
  assign conc = ((xi < xj) == (yi < yj));
  assign tie  = (xi == xj) || (yi == yj);

endmodule

// File: rtl/kendall_stream.sv
// Purpose: collect 4 points, count concordant pairs one per cycle, report tau numerator.
// Latency: result valid 6 edges after the 4th point is accepted.
// Backpressure: in_ready only while loading; result holds in DONE until out_ready.
// Optional out_tie port when KENDALL_TIE_FLAG_EN is defined.
module kendall_stream
  import kendall_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_conc,
  output logic [3:0]         out_tau
`ifdef KENDALL_TIE_FLAG_EN
  ,
  output logic               out_tie
`endif
);

  state_t             state;
  logic [1:0]         cnt;
  logic [2:0]         pidx;
  logic [2:0]         acc;
  logic [COORD_W-1:0] slot_x [NUM_PTS];
  logic [COORD_W-1:0] slot_y [NUM_PTS];
  logic [1:0]         sel_i;
  logic [1:0]         sel_j;
  logic               pair_conc;
  logic               pair_tie;
  logic [2:0]         acc_next;
  logic               accept;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  assign sel_i    = PAIR_I[pidx];
  assign sel_j    = PAIR_J[pidx];
  assign acc_next = acc + {2'b00, pair_conc};

  kendall_pair_cmp u_cmp (
    .xi   (slot_x[sel_i]),
    .yi   (slot_y[sel_i]),
    .xj   (slot_x[sel_j]),
    .yj   (slot_y[sel_j]),
    .conc (pair_conc),
    .tie  (pair_tie)
  );

  // Point storage: written only on an accepted transfer, no reset needed
  // because a set is always fully reloaded before evaluation.
  always_ff @(posedge clk) begin
    if (accept) begin
      slot_x[cnt] <= in_x;
      slot_y[cnt] <= in_y;
    end
  end

`ifdef KENDALL_TIE_FLAG_EN
  logic tie_acc;

  // Sticky tie accumulator for the current set, captured into out_tie at DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tie_acc <= 1'b0;
      out_tie <= 1'b0;
    end else if (state == LOAD) begin
      tie_acc <= 1'b0;
    end else if (state == EVAL) begin
      tie_acc <= tie_acc | pair_tie;
      if (pidx == 3'(NUM_PAIRS - 1)) begin
        out_tie <= tie_acc | pair_tie;
      end
    end
  end
`else
  logic unused_tie;
  assign unused_tie = pair_tie;
`endif

  // Control FSM: LOAD collects points, EVAL walks the 6 pairs, DONE holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOAD;
      cnt      <= 2'd0;
      pidx     <= 3'd0;
      acc      <= 3'd0;
      out_conc <= 3'd0;
      out_tau  <= 4'd0;
    end else begin
      case (state)
        LOAD: begin
          pidx <= 3'd0;
          acc  <= 3'd0;
          if (in_valid) begin
            cnt <= cnt + 2'd1;
            if (cnt == 2'(NUM_PTS - 1)) begin
              state <= EVAL;
            end
          end
        end
        EVAL: begin
          acc  <= acc_next;
          pidx <= pidx + 3'd1;
          if (pidx == 3'(NUM_PAIRS - 1)) begin
            state    <= DONE;
            out_conc <= acc_next;
            out_tau  <= tau_of(acc_next);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= LOAD;
            cnt   <= 2'd0;
          end
        end
        default: begin
          state <= LOAD;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kendall_stream.sv
// Directed bench for kendall_stream: table of 4-point sets with hand-computed
// results, plus backpressure and reset-mid-operation sequences.
// Builds with or without KENDALL_TIE_FLAG_EN.
module tb_kendall_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_x = 4'd0;
  logic [3:0] in_y = 4'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_conc;
  logic [3:0] out_tau;
`ifdef KENDALL_TIE_FLAG_EN
  logic       out_tie;
`endif

  int checks = 0;
  int failures = 0;

  kendall_stream dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_conc  (out_conc),
    .out_tau   (out_tau)
`ifdef KENDALL_TIE_FLAG_EN
    ,
    .out_tie   (out_tie)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] xs;   // point k x-coordinate in bits [4k+3:4k]
    logic [15:0] ys;
    logic [2:0]  conc;
    logic [3:0]  tau;
    logic        tie;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one point and wait (bounded) for it to be accepted.
  task automatic send_point(input logic [3:0] x, input logic [3:0] y);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    in_y = y;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failures++;
      checks++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Load a set, keep junk offered while busy, measure latency, check result.
  task automatic run_set(input string name, input vec_t v);
    int lat;
    for (int k = 0; k < 4; k++) send_point(v.xs[4*k +: 4], v.ys[4*k +: 4]);
    in_valid = 1'b1;
    in_x = 4'hF;
    in_y = 4'h0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      in_x = in_x - 4'd1;
      in_y = in_y + 4'd3;
    end
    chk({name, "_latency"}, lat, 6);
    chk({name, "_conc"}, out_conc, v.conc);
    chk({name, "_tau"}, out_tau, v.tau);
    chk({name, "_in_ready_done"}, in_ready, 0);
`ifdef KENDALL_TIE_FLAG_EN
    chk({name, "_tie"}, out_tie, v.tie);
`endif
  endtask

  // Drop input, accept the result, expect LOAD on the next cycle.
  task automatic release_result(input string name);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({name, "_release"}, {out_valid, in_ready}, 2'b01);
  endtask

  vec_t tbl [7];
  vec_t fresh;

  initial begin
    tbl[0] = '{16'h4321, 16'h4321, 3'd6, 4'b0110, 1'b0};
    tbl[1] = '{16'h4321, 16'h1234, 3'd0, 4'b1010, 1'b0};
    tbl[2] = '{16'h4321, 16'h3412, 3'd4, 4'b0010, 1'b0};
    tbl[3] = '{16'h5555, 16'h4321, 3'd0, 4'b1010, 1'b1};
    tbl[4] = '{16'h0213, 16'h0321, 3'd4, 4'b0010, 1'b0};
    tbl[5] = '{16'h0F0F, 16'h0FF0, 3'd3, 4'b0000, 1'b1};
    tbl[6] = '{16'h7777, 16'h7777, 3'd6, 4'b0110, 1'b1};

    // Reset state
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_conc_tau", {out_conc, out_tau}, 0);
`ifdef KENDALL_TIE_FLAG_EN
    chk("reset_tie", out_tie, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven sets
    for (int t = 0; t < 7; t++) begin
      run_set($sformatf("vec%0d", t), tbl[t]);
      release_result($sformatf("vec%0d", t));
    end

    // Backpressure: hold result for 10 cycles
    run_set("bp", tbl[2]);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d", c), {out_valid, in_ready, out_conc, out_tau},
          {1'b1, 1'b0, 3'd4, 4'b0010});
    end
    release_result("bp");
    run_set("bp_next", tbl[1]);
    release_result("bp_next");

    // Reset mid-EVAL
    for (int k = 0; k < 4; k++) send_point(tbl[0].xs[4*k +: 4], tbl[0].ys[4*k +: 4]);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_eval_state", {out_valid, in_ready}, 2'b01);
    chk("rst_eval_conc_tau", {out_conc, out_tau}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Partial set discarded by reset, then a fresh set
    send_point(4'd9, 4'd9);
    send_point(4'd8, 4'd1);
    #2;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    fresh = tbl[4];
    run_set("after_partial", fresh);

    // Reset while in DONE
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_done_state", {out_valid, in_ready}, 2'b01);
    chk("rst_done_conc_tau", {out_conc, out_tau}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_set("after_done_rst", tbl[1]);
    release_result("after_done_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
